// File: rtl/core_mem_arbiter_if.sv
// core_mem_arbiter_if
//   Bundles the core-array and global-memory signals of core_mem_arbiter.
//   slave  : the arbiter's view (core requests in, memory requests out)
//   master : the surrounding die/testbench view (opposite directions)
//   Core-side vectors are packed per core: core i at [i*width +: width].
interface core_mem_arbiter_if #(
  parameter int unsigned NUM_CORES  = 4,
  parameter int unsigned addr_width = 32,
  parameter int unsigned data_width = 32
);
  logic [NUM_CORES-1:0]            core_rd_req;
  logic [NUM_CORES-1:0]            core_wr_req;
  logic [NUM_CORES*addr_width-1:0] core_addr;
  logic [NUM_CORES*data_width-1:0] core_wr_data;
  logic [data_width-1:0]           core_rd_data;
  logic [NUM_CORES-1:0]            core_busy;
  logic [NUM_CORES-1:0]            core_ack;
  logic                            mem_rd_req;
  logic                            mem_wr_req;
  logic [addr_width-1:0]           mem_addr;
  logic [data_width-1:0]           mem_wr_data;
  logic [data_width-1:0]           mem_rd_data;
  logic                            mem_busy;
  logic                            mem_ack;

  modport slave (
    input  core_rd_req, core_wr_req, core_addr, core_wr_data,
    output core_rd_data, core_busy, core_ack,
    output mem_rd_req, mem_wr_req, mem_addr, mem_wr_data,
    input  mem_rd_data, mem_busy, mem_ack
  );

  modport master (
    output core_rd_req, core_wr_req, core_addr, core_wr_data,
    input  core_rd_data, core_busy, core_ack,
    input  mem_rd_req, mem_wr_req, mem_addr, mem_wr_data,
    output mem_rd_data, mem_busy, mem_ack
  );
endinterface

// File: rtl/core_mem_arbiter.sv
// core_mem_arbiter
//   Shares one global-memory request port among NUM_CORES cores. Each core's
//   one-cycle rd/wr pulse is captured into a per-core buffer; buffered requests
//   are granted round-robin and issued one at a time (IDLE -> REQ -> WAIT).
// Ports
//   clk : clock, rising edge
//   rst : asynchronous active-low reset
//   bus : core_mem_arbiter_if.slave
//         core_rd_req/core_wr_req/core_addr/core_wr_data in, core_rd_data
//         (broadcast), core_busy (pending), core_ack (completion pulse) out;
//         mem_rd_req/mem_wr_req (1-cycle pulses), mem_addr, mem_wr_data out;
//         mem_rd_data, mem_busy (informational), mem_ack in.
module core_mem_arbiter #(
  parameter int unsigned NUM_CORES  = 4,
  parameter int unsigned addr_width = 32,
  parameter int unsigned data_width = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  core_mem_arbiter_if.slave       bus
);
  localparam int unsigned GW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2} state_t;

  state_t                st, st_nxt;
  logic [NUM_CORES-1:0]  pend;
  logic [NUM_CORES-1:0]  op_buf;          // 1 = write
  logic [addr_width-1:0] addr_buf [NUM_CORES];
  logic [data_width-1:0] data_buf [NUM_CORES];
  logic [GW-1:0]         grant, last, pick;
  logic                  pick_valid;
  logic                  op_q;
  logic [addr_width-1:0] addr_q;
  logic [data_width-1:0] wdata_q;
  logic [NUM_CORES-1:0]  ack_vec;
  logic                  done;
  logic                  mem_busy_unused;

  assign mem_busy_unused = bus.mem_busy;
  // mem_ack only completes a transaction that is actually outstanding
  assign done = (st != IDLE) && bus.mem_ack;

  // Round-robin pick: first pending index after the last completed grant
  always_comb begin
    int unsigned idx;
    logic [GW-1:0] cand;
    idx        = 0;
    cand       = '0;
    pick       = last;
    pick_valid = 1'b0;
    for (int unsigned k = 1; k <= NUM_CORES; k++) begin
      idx  = (32'(last) + k) % NUM_CORES;
      cand = GW'(idx);
      if (!pick_valid && pend[cand]) begin
        pick       = cand;
        pick_valid = 1'b1;
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) st <= IDLE;
    else      st <= st_nxt;
  end

  // Next-state logic
  always_comb begin
    st_nxt = st;
    case (st)
      IDLE:    if (pick_valid) st_nxt = REQ;
      REQ:     st_nxt = bus.mem_ack ? IDLE : WAIT;
      WAIT:    if (bus.mem_ack) st_nxt = IDLE;
      default: st_nxt = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    ack_vec = '0;
    if (done) ack_vec[grant] = 1'b1;
    bus.core_ack     = ack_vec;
    bus.core_busy    = pend;
    bus.core_rd_data = bus.mem_rd_data;
    bus.mem_rd_req   = (st == REQ) && !op_q;
    bus.mem_wr_req   = (st == REQ) && op_q;
    bus.mem_addr     = addr_q;
    bus.mem_wr_data  = wdata_q;
  end

  // Grant / in-flight request registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grant   <= '0;
      last    <= GW'(NUM_CORES - 1);
      op_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      if (st == IDLE && pick_valid) begin
        grant   <= pick;
        op_q    <= op_buf[pick];
        addr_q  <= addr_buf[pick];
        wdata_q <= data_buf[pick];
      end
      if (done) last <= grant;
    end
  end

  // Per-core capture. A new pulse in the core's own ack cycle takes priority
  // over the clear, so the buffer reloads and pend stays set.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend   <= '0;
      op_buf <= '0;
      for (int unsigned i = 0; i < NUM_CORES; i++) begin
        addr_buf[i] <= '0;
        data_buf[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_CORES; i++) begin
        if ((bus.core_rd_req[i] || bus.core_wr_req[i]) && (!pend[i] || ack_vec[i])) begin
          pend[i]     <= 1'b1;
          op_buf[i]   <= bus.core_wr_req[i];
          addr_buf[i] <= bus.core_addr[i*addr_width +: addr_width];
          data_buf[i] <= bus.core_wr_data[i*data_width +: data_width];
        end else if (ack_vec[i]) begin
          pend[i] <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_core_mem_arbiter.sv
`timescale 1ns/1ps
module tb_core_mem_arbiter;
  localparam int unsigned NC = 4;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  core_mem_arbiter_if #(.NUM_CORES(NC), .addr_width(AW), .data_width(DW)) bus ();

  core_mem_arbiter #(.NUM_CORES(NC), .addr_width(AW), .data_width(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        rd;
    logic        wr;
  } req_t;

  typedef struct {
    logic [3:0]  vec;
    logic [31:0] data;
    logic [3:0]  busy;
  } ack_t;

  req_t        req_q[$];
  ack_t        ack_q[$];
  int          checks   = 0;
  int          failures = 0;
  logic [31:0] rd_val   = 32'hDEADBEEF;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Memory model: acks 3 cycles after a request with rd_val as read data
  initial begin
    bus.mem_ack     = 1'b0;
    bus.mem_busy    = 1'b0;
    bus.mem_rd_data = '0;
    forever begin
      @(negedge clk);
      if (bus.mem_rd_req || bus.mem_wr_req) begin
        bus.mem_busy = 1'b1;
        repeat (3) @(negedge clk);
        bus.mem_ack     = 1'b1;
        bus.mem_rd_data = rd_val;
        @(negedge clk);
        bus.mem_ack     = 1'b0;
        bus.mem_busy    = 1'b0;
        bus.mem_rd_data = '0;
      end
    end
  end

  task automatic set_core(input int unsigned i, input logic [31:0] a, input logic [31:0] d);
    bus.core_addr[i*AW +: AW]    = a;
    bus.core_wr_data[i*DW +: DW] = d;
  endtask

  task automatic pulse(input logic [3:0] rd, input logic [3:0] wr);
    @(negedge clk);
    bus.core_rd_req = rd;
    bus.core_wr_req = wr;
  endtask

  // Runs n cycles, clearing pulses and logging memory requests and acks.
  // With repulse0, core 0 re-pulses a read (address re_addr) in its first ack cycle.
  task automatic run_cycles(input int n, input bit repulse0, input logic [31:0] re_addr);
    bit fired;
    fired = 1'b0;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      bus.core_rd_req = '0;
      bus.core_wr_req = '0;
      #1;
      if (bus.mem_rd_req || bus.mem_wr_req)
        req_q.push_back('{addr: bus.mem_addr, data: bus.mem_wr_data,
                          rd: bus.mem_rd_req, wr: bus.mem_wr_req});
      if (bus.core_ack != '0) begin
        ack_q.push_back('{vec: bus.core_ack, data: bus.core_rd_data, busy: bus.core_busy});
        if (repulse0 && bus.core_ack[0] && !fired) begin
          set_core(0, re_addr, 32'h0);
          bus.core_rd_req[0] = 1'b1;
          fired = 1'b1;
        end
      end
    end
  endtask

  task automatic clear_logs();
    req_q.delete();
    ack_q.delete();
  endtask

  initial begin
    bus.core_rd_req  = '0;
    bus.core_wr_req  = '0;
    bus.core_addr    = '0;
    bus.core_wr_data = '0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_eq("rst_busy",  64'(bus.core_busy),   64'h0);
    check_eq("rst_ack",   64'(bus.core_ack),    64'h0);
    check_eq("rst_rdreq", 64'(bus.mem_rd_req),  64'h0);
    check_eq("rst_wrreq", 64'(bus.mem_wr_req),  64'h0);
    check_eq("rst_addr",  64'(bus.mem_addr),    64'h0);
    check_eq("rst_wdata", 64'(bus.mem_wr_data), 64'h0);
    @(negedge clk);
    rst = 1'b1;

    // 1) core 2 single read
    clear_logs();
    rd_val = 32'hDEADBEEF;
    set_core(2, 32'h100, 32'h0);
    pulse(4'b0100, 4'b0000);
    run_cycles(12, 1'b0, 32'h0);
    check_eq("t1_nreq",  64'(req_q.size()), 64'd1);
    check_eq("t1_addr",  64'(req_q[0].addr), 64'h100);
    check_eq("t1_rd",    64'(req_q[0].rd),   64'h1);
    check_eq("t1_wr",    64'(req_q[0].wr),   64'h0);
    check_eq("t1_nack",  64'(ack_q.size()),  64'd1);
    check_eq("t1_ackv",  64'(ack_q[0].vec),  64'h4);
    check_eq("t1_rdata", 64'(ack_q[0].data), 64'hDEADBEEF);

    // 2) cores 0,1,3 together from reset, then 0 and 3 with last=3
    @(negedge clk); rst = 1'b0;
    @(negedge clk); rst = 1'b1;
    clear_logs();
    set_core(0, 32'h1000, 32'h0);
    set_core(1, 32'h1100, 32'h0);
    set_core(3, 32'h1300, 32'h0);
    pulse(4'b1011, 4'b0000);
    run_cycles(25, 1'b0, 32'h0);
    check_eq("t2_nreq",  64'(req_q.size()), 64'd3);
    check_eq("t2_addr0", 64'(req_q[0].addr), 64'h1000);
    check_eq("t2_addr1", 64'(req_q[1].addr), 64'h1100);
    check_eq("t2_addr2", 64'(req_q[2].addr), 64'h1300);
    check_eq("t2_nack",  64'(ack_q.size()),  64'd3);
    check_eq("t2_ack0",  64'(ack_q[0].vec),  64'h1);
    check_eq("t2_ack1",  64'(ack_q[1].vec),  64'h2);
    check_eq("t2_ack2",  64'(ack_q[2].vec),  64'h8);
    check_eq("t2_busy0", 64'(ack_q[0].busy), 64'hB);
    check_eq("t2_busy1", 64'(ack_q[1].busy), 64'hA);
    check_eq("t2_busy2", 64'(ack_q[2].busy), 64'h8);
    clear_logs();
    set_core(0, 32'h2000, 32'h0);
    set_core(3, 32'h2300, 32'h0);
    pulse(4'b1001, 4'b0000);
    run_cycles(20, 1'b0, 32'h0);
    check_eq("t2b_nreq",  64'(req_q.size()), 64'd2);
    check_eq("t2b_addr0", 64'(req_q[0].addr), 64'h2000);
    check_eq("t2b_addr1", 64'(req_q[1].addr), 64'h2300);
    check_eq("t2b_ack0",  64'(ack_q[0].vec),  64'h1);
    check_eq("t2b_ack1",  64'(ack_q[1].vec),  64'h8);

    // 3) core 1 write
    clear_logs();
    set_core(1, 32'h40, 32'h1234);
    pulse(4'b0000, 4'b0010);
    run_cycles(1, 1'b0, 32'h0);
    check_eq("t3_busy_early", 64'(bus.core_busy), 64'h2);
    run_cycles(12, 1'b0, 32'h0);
    check_eq("t3_nreq",  64'(req_q.size()), 64'd1);
    check_eq("t3_addr",  64'(req_q[0].addr), 64'h40);
    check_eq("t3_data",  64'(req_q[0].data), 64'h1234);
    check_eq("t3_wr",    64'(req_q[0].wr),   64'h1);
    check_eq("t3_rd",    64'(req_q[0].rd),   64'h0);
    check_eq("t3_nack",  64'(ack_q.size()),  64'd1);
    check_eq("t3_ackv",  64'(ack_q[0].vec),  64'h2);
    check_eq("t3_busyack", 64'(ack_q[0].busy), 64'h2);
    check_eq("t3_busy_end", 64'(bus.core_busy), 64'h0);

    // 4) core 0 re-pulses in its own ack cycle
    clear_logs();
    set_core(0, 32'h10, 32'h0);
    pulse(4'b0001, 4'b0000);
    run_cycles(20, 1'b1, 32'h20);
    check_eq("t4_nreq",  64'(req_q.size()), 64'd2);
    check_eq("t4_addr0", 64'(req_q[0].addr), 64'h10);
    check_eq("t4_addr1", 64'(req_q[1].addr), 64'h20);
    check_eq("t4_nack",  64'(ack_q.size()),  64'd2);
    check_eq("t4_ack1",  64'(ack_q[1].vec),  64'h1);
    check_eq("t4_busy_end", 64'(bus.core_busy), 64'h0);

    // 5) reset while in WAIT; late mem_ack must be ignored
    clear_logs();
    set_core(1, 32'h80, 32'h0);
    pulse(4'b0010, 4'b0000);
    run_cycles(3, 1'b0, 32'h0);
    check_eq("t5_issued", 64'(req_q.size()), 64'd1);
    #2 rst = 1'b0;
    #1;
    check_eq("t5_rdreq", 64'(bus.mem_rd_req),  64'h0);
    check_eq("t5_wrreq", 64'(bus.mem_wr_req),  64'h0);
    check_eq("t5_addr",  64'(bus.mem_addr),    64'h0);
    check_eq("t5_wdata", 64'(bus.mem_wr_data), 64'h0);
    check_eq("t5_busy",  64'(bus.core_busy),   64'h0);
    check_eq("t5_ack",   64'(bus.core_ack),    64'h0);
    @(negedge clk);
    rst = 1'b1;
    clear_logs();
    run_cycles(6, 1'b0, 32'h0);
    check_eq("t5_lateack", 64'(ack_q.size()), 64'd0);
    check_eq("t5_noreq",   64'(req_q.size()), 64'd0);
    set_core(3, 32'h300, 32'h0);
    pulse(4'b1000, 4'b0000);
    run_cycles(12, 1'b0, 32'h0);
    check_eq("t5_nreq",  64'(req_q.size()), 64'd1);
    check_eq("t5_addr2", 64'(req_q[0].addr), 64'h300);
    check_eq("t5_ackv",  64'(ack_q[0].vec),  64'h8);

    // 6) rd and wr together: write wins
    clear_logs();
    set_core(2, 32'h200, 32'h55AA);
    pulse(4'b0100, 4'b0100);
    run_cycles(12, 1'b0, 32'h0);
    check_eq("t6_nreq", 64'(req_q.size()), 64'd1);
    check_eq("t6_wr",   64'(req_q[0].wr),   64'h1);
    check_eq("t6_rd",   64'(req_q[0].rd),   64'h0);
    check_eq("t6_addr", 64'(req_q[0].addr), 64'h200);
    check_eq("t6_data", 64'(req_q[0].data), 64'h55AA);
    check_eq("t6_ackv", 64'(ack_q[0].vec),  64'h4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
